// File: rtl/nx_pkg.sv
// nx_pkg: shared definitions for the nx stream blocks.
// Holds the default stream parameters and the mesh direction encoding
// used when a fan-out instance serves the four ports of a mesh router.
package nx_pkg;

    localparam int NX_STREAM_WIDTH = 32;
    localparam int NX_OUTPUTS      = 4;
    localparam int NX_FIFO_DEPTH   = 2;

    // Direction index for the 4-output mesh configuration.
    typedef enum logic [1:0] {
        NORTH = 2'd0,
        EAST  = 2'd1,
        SOUTH = 2'd2,
        WEST  = 2'd3
    } nx_dir_e;

endpackage

// File: rtl/nx_fifo.sv
// nx_fifo: synchronous FIFO buffer, DEPTH entries of WIDTH bits.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (control state only)
//   push_i        write data_i (ignored when full)
//   data_i        write data
//   pop_i         remove head entry (ignored when empty)
//   data_o        head entry; don't-care while empty
//   full_o        occupancy == DEPTH
//   empty_o       occupancy == 0
//   level_o       current occupancy, 0..DEPTH
// All outputs depend only on registered state.
module nx_fifo
    import nx_pkg::*;
#(
    parameter int WIDTH = NX_STREAM_WIDTH,
    parameter int DEPTH = NX_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the occupancy counter alone decides validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/nx_stream_fanout.sv
// nx_stream_fanout: steers one inbound message stream to OUTPUTS outbound
// streams, each behind its own FIFO_DEPTH-entry buffer.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   dist_data_i    inbound message
//   dist_dir_i     target outbound index (unicast)
//   dist_bcast_i   write every outbound buffer, dist_dir_i ignored
//   dist_valid_i   inbound valid
//   dist_ready_o   inbound ready
//   out_data_o     per-stream head of buffer
//   out_valid_o    per-stream buffer not empty
//   out_ready_i    per-stream consumer ready
//   drop_o         one-cycle pulse after an out-of-range unicast is discarded
//   idle_o         all buffers empty
//
// Handshake: a transfer happens on every rising clk_i edge where valid and
// ready are both high; valid may not depend on ready. dist_ready_o is built
// from registered buffer occupancy only, so a pop on out_ready_i frees space
// for the inbound side one cycle later, never in the same cycle.
module nx_stream_fanout
    import nx_pkg::*;
#(
    parameter int STREAM_WIDTH = NX_STREAM_WIDTH,
    parameter int OUTPUTS      = NX_OUTPUTS,
    parameter int FIFO_DEPTH   = NX_FIFO_DEPTH,
    localparam int DIR_W       = $clog2(OUTPUTS)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [STREAM_WIDTH-1:0]               dist_data_i,
    input  logic [DIR_W-1:0]                      dist_dir_i,
    input  logic                                  dist_bcast_i,
    input  logic                                  dist_valid_i,
    output logic                                  dist_ready_o,
    output logic [OUTPUTS-1:0][STREAM_WIDTH-1:0]  out_data_o,
    output logic [OUTPUTS-1:0]                    out_valid_o,
    input  logic [OUTPUTS-1:0]                    out_ready_i,
    output logic                                  drop_o,
    output logic                                  idle_o
);

    localparam int NPAD  = 1 << DIR_W;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [OUTPUTS-1:0] full_w;
    logic [OUTPUTS-1:0] empty_w;
    logic [OUTPUTS-1:0] push_w;
    logic [LVL_W-1:0]   level_w [OUTPUTS];
    logic [NPAD-1:0]    full_pad;
    logic               dir_oor;
    logic               accept;
    logic               drop_q, drop_d;

    // Direction codes beyond OUTPUTS-1 see a "never full" slot, so an
    // out-of-range unicast is always accepted and then discarded.
    generate
        if (NPAD == OUTPUTS) begin : g_dir_exact
            assign full_pad = full_w;
            assign dir_oor  = 1'b0;
        end else begin : g_dir_padded
            assign full_pad = {{(NPAD - OUTPUTS){1'b0}}, full_w};
            assign dir_oor  = (int'(dist_dir_i) >= OUTPUTS);
        end
    endgenerate

    // Broadcast needs room everywhere so it lands in all buffers at once.
    assign dist_ready_o = dist_bcast_i ? ~|full_w : ~full_pad[dist_dir_i];
    assign accept       = dist_valid_i && dist_ready_o;

    generate
        for (genvar n = 0; n < OUTPUTS; n++) begin : g_buf
            // An out-of-range direction never matches, so nothing is pushed.
            assign push_w[n] = accept &&
                               (dist_bcast_i || (dist_dir_i == DIR_W'(n)));

            nx_fifo #(
                .WIDTH (STREAM_WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .push_i  (push_w[n]),
                .data_i  (dist_data_i),
                .pop_i   (out_ready_i[n]),
                .data_o  (out_data_o[n]),
                .full_o  (full_w[n]),
                .empty_o (empty_w[n]),
                .level_o (level_w[n])
            );
        end
    endgenerate

    assign out_valid_o = ~empty_w;

    assign drop_d = accept && !dist_bcast_i && dir_oor;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_o = drop_q;

    // Derived from the registered occupancy counters only.
    always_comb begin
        idle_o = 1'b1;
        for (int n = 0; n < OUTPUTS; n++) begin
            if (level_w[n] != '0) begin
                idle_o = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nx_stream_fanout.sv
module tb_nx_stream_fanout;

    import nx_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // DUT A: default parameters (4 outputs, depth 2)
    logic [31:0]       data_a;
    logic [1:0]        dir_a;
    logic              bcast_a;
    logic              valid_a;
    logic              ready_a;
    logic [3:0][31:0]  out_data_a;
    logic [3:0]        out_valid_a;
    logic [3:0]        oready_a;
    logic              drop_a;
    logic              idle_a;

    // DUT B: 3 outputs, so direction code 3 is out of range
    logic [31:0]       data_b;
    logic [1:0]        dir_b;
    logic              bcast_b;
    logic              valid_b;
    logic              ready_b;
    logic [2:0][31:0]  out_data_b;
    logic [2:0]        out_valid_b;
    logic [2:0]        oready_b;
    logic              drop_b;
    logic              idle_b;

    nx_stream_fanout dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .dist_data_i  (data_a),
        .dist_dir_i   (dir_a),
        .dist_bcast_i (bcast_a),
        .dist_valid_i (valid_a),
        .dist_ready_o (ready_a),
        .out_data_o   (out_data_a),
        .out_valid_o  (out_valid_a),
        .out_ready_i  (oready_a),
        .drop_o       (drop_a),
        .idle_o       (idle_a)
    );

    nx_stream_fanout #(.STREAM_WIDTH(32), .OUTPUTS(3), .FIFO_DEPTH(2)) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .dist_data_i  (data_b),
        .dist_dir_i   (dir_b),
        .dist_bcast_i (bcast_b),
        .dist_valid_i (valid_b),
        .dist_ready_o (ready_b),
        .out_data_o   (out_data_b),
        .out_valid_o  (out_valid_b),
        .out_ready_i  (oready_b),
        .drop_o       (drop_b),
        .idle_o       (idle_b)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns 1 just after a rising edge; inputs are driven here and
    // outputs sampled a few time units later, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        valid;
        logic        bcast;
        logic [1:0]  dir;
        logic [31:0] data;
        logic [3:0]  oready;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic        exp_idle;
        int          lane;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int recv;
        int occ;
        logic acc;
        logic pop_m;
        logic [31:0] want;

        // Expected outputs describe state produced by earlier edges; each
        // row's inputs take effect at the edge that follows its checks.
        vecs[0] = '{1'b1, 1'b0, 2'(SOUTH), 32'hA5A5_0001, 4'hF, 1'b1, 4'b0000, 1'b1, 0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 32'h0,          4'hF, 1'b1, 4'b0100, 1'b0, 2, 32'hA5A5_0001};
        vecs[2] = '{1'b0, 1'b0, 2'd0, 32'h0,          4'hF, 1'b1, 4'b0000, 1'b1, 0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h0000_BEEF,  4'hF, 1'b1, 4'b0000, 1'b1, 0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 2'd0, 32'h0000_0011,  4'hF, 1'b1, 4'b1111, 1'b0, 0, 32'h0000_BEEF};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 32'h0000_0033,  4'hF, 1'b1, 4'b0001, 1'b0, 0, 32'h0000_0011};
        vecs[6] = '{1'b0, 1'b0, 2'd0, 32'h0,          4'hF, 1'b1, 4'b1000, 1'b0, 3, 32'h0000_0033};
        vecs[7] = '{1'b0, 1'b0, 2'd0, 32'h0,          4'hF, 1'b1, 4'b0000, 1'b1, 0, 32'h0};

        rst      = 1'b1;
        data_a   = '0; dir_a = '0; bcast_a = 1'b0; valid_a = 1'b0; oready_a = '0;
        data_b   = '0; dir_b = '0; bcast_b = 1'b0; valid_b = 1'b0; oready_b = '0;

        // ---- reset state ----
        #2;
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_valid", out_valid_a, 4'b0000);
        chk("rst_idle", idle_a, 1'b1);
        chk("rst_drop", drop_a, 1'b0);
        chk("rst_idle_b", idle_b, 1'b1);
        chk("rst_drop_b", drop_b, 1'b0);
        step();
        step();
        rst = 1'b0;

        // ---- table-driven unicast / broadcast ----
        for (int i = 0; i < 8; i++) begin
            valid_a  = vecs[i].valid;
            bcast_a  = vecs[i].bcast;
            dir_a    = vecs[i].dir;
            data_a   = vecs[i].data;
            oready_a = vecs[i].oready;
            #1;
            chk($sformatf("vec%0d_ready", i), ready_a, vecs[i].exp_ready);
            chk($sformatf("vec%0d_valid", i), out_valid_a, vecs[i].exp_valid);
            chk($sformatf("vec%0d_idle", i), idle_a, vecs[i].exp_idle);
            chk($sformatf("vec%0d_drop", i), drop_a, 1'b0);
            if (vecs[i].exp_valid[vecs[i].lane]) begin
                chk($sformatf("vec%0d_data", i), out_data_a[vecs[i].lane], vecs[i].exp_data);
            end
            step();
        end
        valid_a = 1'b0;
        bcast_a = 1'b0;

        // ---- backpressure on output 1 ----
        oready_a = 4'b1101;
        valid_a  = 1'b1; dir_a = 2'(EAST); data_a = 32'd1;
        #1 chk("bp_ready1", ready_a, 1'b1);
        step();
        data_a = 32'd2;
        #1 chk("bp_ready2", ready_a, 1'b1);
        chk("bp_head1", out_data_a[1], 32'd1);
        step();
        data_a = 32'd3;
        #1 chk("bp_full", ready_a, 1'b0);
        step();
        #1 chk("bp_held", ready_a, 1'b0);
        chk("bp_head1b", out_data_a[1], 32'd1);
        oready_a[1] = 1'b1;
        #1 chk("bp_no_comb", ready_a, 1'b0);
        step();
        #1 chk("bp_ready3", ready_a, 1'b1);
        chk("bp_head2", out_data_a[1], 32'd2);
        step();
        valid_a = 1'b0;
        #1 chk("bp_valid3", out_valid_a, 4'b0010);
        chk("bp_head3", out_data_a[1], 32'd3);
        step();
        #1 chk("bp_empty", out_valid_a, 4'b0000);
        chk("bp_idle", idle_a, 1'b1);

        // ---- broadcast blocked by a full buffer 3 ----
        oready_a = 4'b0111;
        valid_a  = 1'b1; bcast_a = 1'b0; dir_a = 2'(WEST); data_a = 32'h31;
        step();
        data_a = 32'h32;
        step();
        bcast_a = 1'b1; data_a = 32'h0000_BEEF;
        #1 chk("bc_blocked", ready_a, 1'b0);
        chk("bc_valid_pre", out_valid_a, 4'b1000);
        step();
        #1 chk("bc_nowrite", out_valid_a, 4'b1000);
        chk("bc_still_blocked", ready_a, 1'b0);
        oready_a[3] = 1'b1;
        #1 chk("bc_no_comb", ready_a, 1'b0);
        step();
        #1 chk("bc_ready", ready_a, 1'b1);
        step();
        valid_a = 1'b0; bcast_a = 1'b0; oready_a = 4'b1111;
        #1 chk("bc_all_valid", out_valid_a, 4'b1111);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("bc_data%0d", n), out_data_a[n], 32'h0000_BEEF);
        end
        step();
        #1 chk("bc_idle", idle_a, 1'b1);

        // ---- out-of-range unicast on the 3-output instance ----
        oready_b = 3'b111;
        valid_b  = 1'b1; dir_b = 2'd3; data_b = 32'h77;
        #1 chk("oor_ready", ready_b, 1'b1);
        step();
        valid_b = 1'b0;
        #1 chk("oor_drop", drop_b, 1'b1);
        chk("oor_valid", out_valid_b, 3'b000);
        chk("oor_idle", idle_b, 1'b1);
        step();
        #1 chk("oor_drop_end", drop_b, 1'b0);
        chk("oor_valid2", out_valid_b, 3'b000);
        valid_b = 1'b1; dir_b = 2'd1; data_b = 32'h88;
        step();
        valid_b = 1'b0;
        #1 chk("inr_valid", out_valid_b, 3'b010);
        chk("inr_data", out_data_b[1], 32'h88);
        chk("inr_drop", drop_b, 1'b0);
        step();

        // ---- asynchronous reset mid-operation ----
        oready_a = 4'b0000;
        valid_a  = 1'b1; dir_a = 2'(NORTH); data_a = 32'h51;
        step();
        data_a = 32'h52;
        step();
        valid_a = 1'b0;
        #1 chk("mr_filled", out_valid_a, 4'b0001);
        rst = 1'b1;
        #1 chk("mr_valid", out_valid_a, 4'b0000);
        chk("mr_idle", idle_a, 1'b1);
        chk("mr_ready", ready_a, 1'b1);
        valid_a = 1'b1; data_a = 32'h53;
        step();
        rst = 1'b0; valid_a = 1'b0; oready_a = 4'b1111;
        #1 chk("mr_ignored", out_valid_a, 4'b0000);
        chk("mr_idle2", idle_a, 1'b1);
        step();
        #1 chk("mr_no_stale", out_valid_a, 4'b0000);

        // ---- wrap: 10 messages to output 0, consumer toggling ----
        sent = 0; recv = 0; occ = 0;
        for (int cyc = 0; cyc < 100 && recv < 10; cyc++) begin
            oready_a    = 4'b1110;
            oready_a[0] = (cyc % 2) == 1;
            valid_a     = (sent < 10);
            dir_a       = 2'(NORTH);
            data_a      = 32'h100 + 32'(sent);
            #1;
            chk("wrap_ready", ready_a, occ < 2);
            chk("wrap_valid", out_valid_a[0], occ > 0);
            acc   = valid_a && (occ < 2);
            pop_m = (occ > 0) && oready_a[0];
            if (pop_m) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
                chk("wrap_data", out_data_a[0], want);
                recv++;
            end
            if (acc) begin
                exp_q.push_back(data_a);
                sent++;
            end
            occ = occ + int'(acc) - int'(pop_m);
            step();
        end
        valid_a = 1'b0;
        chk("wrap_count", recv, 10);
        step();
        #1 chk("wrap_idle", idle_a, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nx_stream_fanout.md
NX_STREAM_FANOUT -- requirements
Module: nx_stream_fanout

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32, meaning message data width in bits.
REQ-002 SHALL have parameter OUTPUTS, default 4, meaning number of outbound streams (legal range 2..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning entries per outbound buffer (power of two, 2 or more).
REQ-004 SHALL have ports in this order:
- clk_i  input  1  clock, the block's one clock.
- rst_i  input  1  reset, asynchronous and active-high.
- dist_data_i  input  STREAM_WIDTH  inbound message.
- dist_dir_i  input  DIR_W=$clog2(OUTPUTS)  target outbound index.
- dist_bcast_i  input  1  broadcast to all outputs; dist_dir_i is ignored.
- dist_valid_i  input  1  inbound valid.
- dist_ready_o  output  1  inbound ready.
- out_data_o  output  OUTPUTS x STREAM_WIDTH  outbound data per stream.
- out_valid_o  output  OUTPUTS  outbound valid per stream.
- out_ready_i  input  OUTPUTS  outbound ready per stream.
- drop_o  output  1  one-cycle pulse when an out-of-range message is discarded.
- idle_o  output  1  high when all buffers are empty.

Function
REQ-005 SHALL accept an inbound message on a cycle where dist_valid_i && dist_ready_o at the rising edge of clk_i.
REQ-006 SHALL set dist_ready_o for unicast to "buffer[dist_dir_i] not full", using the registered occupancy only.
REQ-007 SHALL set dist_ready_o for broadcast to "no buffer full"; an accepted broadcast writes every buffer in the same cycle. Broadcast is all-or-nothing and never partial.
REQ-008 SHALL have no combinational path from any out_ready_i to dist_ready_o, so a pop does not free space in the same cycle.
REQ-009 SHALL, for a unicast with dist_dir_i >= OUTPUTS, hold dist_ready_o=1, discard the message, and pulse drop_o for exactly one cycle after acceptance. Buffer state is unchanged.
REQ-010 SHALL drive out_valid_o[n] = buffer n not empty and out_data_o[n] = head of buffer n, both registered.
REQ-011 SHALL pop buffer n on out_valid_o[n] && out_ready_i[n].
REQ-012 SHALL have latency of 1 cycle: a message accepted at edge k appears on out_valid_o at k+1 when its target buffer was empty.
REQ-013 SHALL, on a simultaneous push and pop of the same buffer, leave occupancy unchanged and preserve FIFO order.
REQ-014 SHALL have each buffer hold FIFO_DEPTH entries, with read/write pointers of $clog2(FIFO_DEPTH) bits wrapping modulo FIFO_DEPTH and a separate occupancy counter of $clog2(FIFO_DEPTH)+1 bits.
REQ-015 SHALL drive idle_o = 1 only when every occupancy is 0, registered.
REQ-016 SHALL make out_data_o of an empty buffer don't-care, while out_valid_o stays low.
REQ-017 SHALL keep messages from one inbound stream delivered in acceptance order per output.

Reset
REQ-018 SHALL on rst_i assertion asynchronously clear all pointers and occupancies; out_valid_o=0, drop_o=0, idle_o=1.
REQ-019 SHALL drive dist_ready_o=1 while in reset (all buffers empty), but ignore any transfer at an edge where rst_i is high.
REQ-020 SHALL discard all buffered contents when reset is asserted mid-operation; no message accepted before reset is emitted after it.
REQ-021 SHALL need no data-storage reset; only control state is reset.

Structure
REQ-022 SHALL keep the default parameters and a shared direction enum (NORTH=0, EAST=1, SOUTH=2, WEST=3) in the shared nx package, for the 4-output mesh use.
REQ-023 SHALL implement each outbound buffer as one instance of sub-module nx_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level), generated OUTPUTS times.
REQ-024 SHALL keep broadcast/unicast steering and drop logic in the top level; nx_fifo holds no routing knowledge.

Verification
REQ-025 SHALL cover unicast: data=0xA5A5_0001, dir=2, all out_ready_i=1 -> out_valid_o=4'b0100 at the next cycle with data 0xA5A5_0001; idle_o returns to 1 one cycle after the pop.
REQ-026 SHALL cover backpressure: out_ready_i[1]=0, three messages to dir=1 with FIFO_DEPTH=2 -> dist_ready_o falls after the 2nd accept; the 3rd is accepted only the cycle after out_ready_i[1] rises; order 1,2,3 is preserved.
REQ-027 SHALL cover broadcast: bcast=1, data=0x0000_BEEF, out_ready_i[3]=0 with buffer 3 full -> dist_ready_o=0, no buffer written; after a drain the message appears on all four outputs in the same cycle.
REQ-028 SHALL cover out-of-range: OUTPUTS=3, dir=3, valid=1 -> dist_ready_o=1, drop_o high for one cycle, all out_valid_o stay 0.
REQ-029 SHALL cover mid-operation reset: fill buffer 0 with 2 entries, pulse rst_i asynchronously between edges -> out_valid_o=0 immediately and idle_o=1; no stale data after release.
REQ-030 SHALL cover wrap: 10 messages to dir=0 with out_ready_i[0] toggling every cycle -> all 10 are received in order, with occupancy never exceeding 2.
